dec_out_arbiter: RTL and testbench
==================================

# dec_out_arbiter

Parametrised N-channel output stage for the decryption datapath, replacing the fixed three-input registered selector. Each decoder channel writes into its own small FIFO. One registered output port drains the FIFOs with a ready/valid handshake, either from a fixed selected channel or round-robin across all non-empty channels. Sits between the per-cipher decoder outputs and the top-level output interface.

## Interface
- D_WIDTH, 8, data word width
- N_CH, 4, number of input channels (2..16); SEL_W = $clog2(N_CH), derived, not overridable
- FIFO_DEPTH, 4, words per channel FIFO (power of 2, >= 2)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- data_i  in  N_CH*D_WIDTH  channel k word at bits [k*D_WIDTH +: D_WIDTH]
- valid_i  in  N_CH  per-channel write strobe
- ready_o  out  N_CH  per-channel space available
- overflow_o  out  N_CH  sticky: write attempted while channel full
- mode  in  1  0 = fixed select, 1 = round-robin
- select  in  SEL_W  source channel in fixed mode
- data_o  out  D_WIDTH  output word
- valid_o  out  1  output word valid
- chan_o  out  SEL_W  channel index of the current data_o
- ready_i  in  1  downstream accepts data_o

## Operation
- Push: channel k writes when valid_i[k] && ready_o[k]. ready_o[k] = !rst && (count_k < FIFO_DEPTH). No push into a full FIFO, even if that FIFO pops in the same cycle.
- Overflow: valid_i[k] && !ready_o[k] outside reset sets overflow_o[k]. Only rst clears it. The word is dropped.
- Load condition: load = !valid_o || ready_i.
- Fixed mode: on load, if select < N_CH and FIFO[select] is non-empty, pop it into the output register. select >= N_CH never grants.
- Round-robin mode: on load, grant the first non-empty channel searching from rr_ptr+1 upward, with modulo-N_CH wrap. Then set rr_ptr to the granted channel. rr_ptr does not move when no grant is made, and does not move in fixed mode.
- Output register, when load is true and a grant is made: data_o gets the FIFO head, chan_o gets the granted channel, valid_o = 1.
- Output register, when load is true and no grant is made: valid_o = 0, data_o = 0, chan_o holds its value.
- Output register, when load is false (valid_o && !ready_i): data_o, chan_o and valid_o hold.
- Same-cycle push and pop on one channel: both take effect and the count is unchanged. The pushed word is only the head if the FIFO was empty, in which case it cannot also be popped that cycle.
- Changes to mode or select affect only the next grant. A word already in the output register is never replaced.
- Counters: per-channel read/write pointers of $clog2(FIFO_DEPTH) bits wrap naturally. count is $clog2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values (asserted at the edge): data_o=0, valid_o=0, chan_o=0, overflow_o=0, all FIFOs empty, rr_ptr=N_CH-1 so channel 0 wins first. ready_o=0 while rst is high and all ones on the first cycle after.
- Reset mid-operation discards FIFO contents and the output word without completing any handshake.
- Latency: a word pushed at edge t into an empty FIFO, with the output register free, has valid_o=1 after edge t+1. Minimum latency is 2 edges, with no bypass path.
- Throughput: one word per clock when ready_i stays high and a grant source stays non-empty.
- Backpressure: while valid_o && !ready_i, no pops occur. FIFOs fill, ready_o falls at count == FIFO_DEPTH, and it rises the cycle after a pop.
- Handshake: data_o, chan_o and valid_o change only on clk. Downstream samples when valid_o && ready_i.

## Test plan
- Reset: hold rst for 3 cycles with valid_i all ones -> valid_o=0, data_o=0, ready_o=0, overflow_o=0 throughout; ready_o=4'hF on the first cycle after release.
- Fixed mode, N_CH=4: mode=0, select=2, push 8'hA5 on ch2 at edge t, ready_i=1 -> data_o=8'hA5, chan_o=2, valid_o=1 after edge t+1. Words on ch0 stay buffered with no output.
- Round-robin: mode=1, preload ch0={8'h10,8'h11}, ch1={8'h20}, ch3={8'h30}, ready_i=1 -> output sequence 10(ch0), 20(ch1), 30(ch3), 11(ch0), then valid_o=0 and data_o=0.
- Backpressure/full: ready_i=0, push 5 words on ch1 with FIFO_DEPTH=4 -> ready_o[1]=0 after the 4th push, overflow_o[1]=1 after the 5th. Raising ready_i drains the first 4 words in order.
- Out-of-range select with N_CH=3: select=3, ch0 non-empty -> valid_o stays 0. Switching to select=0 -> ch0 head appears after the next edge.
- Mid-run reset: rst asserted for one cycle with valid_o=1 and FIFOs half full -> all FIFOs empty and valid_o=0 after that edge; rr restarts at ch0.

Source files
------------

// File: rtl/dec_out_arbiter.sv
// dec_out_arbiter: N-channel FIFO output stage draining onto one registered ready/valid port.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   data_i/valid_i  - per-channel write words/strobes (channel k at [k*D_WIDTH +: D_WIDTH])
//   ready_o         - per-channel FIFO space available
//   overflow_o      - sticky per-channel drop flag, cleared only by rst
//   mode/select     - 0 = fixed channel select, 1 = round-robin over non-empty channels
//   data_o/valid_o/chan_o/ready_i - registered output word, valid, source channel, downstream ready
module dec_out_arbiter #(
    parameter int D_WIDTH = 8,
    parameter int N_CH = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH*D_WIDTH-1:0] data_i,
    input  logic [N_CH-1:0]         valid_i,
    output logic [N_CH-1:0]         ready_o,
    output logic [N_CH-1:0]         overflow_o,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        select,
    output logic [D_WIDTH-1:0]      data_o,
    output logic                    valid_o,
    output logic [SEL_W-1:0]        chan_o,
    input  logic                    ready_i
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    logic [D_WIDTH-1:0] mem [N_CH][FIFO_DEPTH];
    logic [AW-1:0]      wptr [N_CH];
    logic [AW-1:0]      rptr [N_CH];
    logic [AW:0]        cnt [N_CH];
    logic [SEL_W-1:0]   rr_ptr;
    logic [N_CH-1:0]    nonempty, push, pop;
    logic               load, found, grant;
    logic [SEL_W-1:0]   gch;
    logic [D_WIDTH-1:0] head;
    int                 j;

    always_comb begin
        nonempty = '0;
        ready_o = '0;
        push = '0;
        pop = '0;
        found = 1'b0;
        gch = '0;
        head = '0;
        j = 0;
        for (int k = 0; k < N_CH; k++) begin
            nonempty[k] = cnt[k] != '0;
            ready_o[k] = !rst && cnt[k] != FULL;
            push[k] = valid_i[k] && ready_o[k];
        end
        load = !valid_o || ready_i;
        if (!mode) begin
            // An out-of-range select matches no channel, so it never grants.
            for (int k = 0; k < N_CH; k++)
                if (select == SEL_W'(k) && nonempty[k]) begin
                    found = 1'b1;
                    gch = SEL_W'(k);
                end
        end else begin
            // Scan downward so the last hit is the nearest channel after rr_ptr.
            for (int i = N_CH; i >= 1; i--) begin
                j = (int'(rr_ptr) + i) % N_CH;
                if (nonempty[j]) begin
                    found = 1'b1;
                    gch = SEL_W'(j);
                end
            end
        end
        grant = load && found;
        for (int k = 0; k < N_CH; k++) begin
            pop[k] = grant && gch == SEL_W'(k);
            head = gch == SEL_W'(k) ? mem[k][rptr[k]] : head;
        end
    end

    always_ff @(posedge clk)
        for (int k = 0; k < N_CH; k++)
            if (push[k])
                mem[k][wptr[k]] <= data_i[k*D_WIDTH +: D_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                wptr[k] <= '0;
                rptr[k] <= '0;
                cnt[k] <= '0;
            end
            overflow_o <= '0;
            data_o <= '0;
            valid_o <= 1'b0;
            chan_o <= '0;
            rr_ptr <= SEL_W'(N_CH - 1);
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                wptr[k] <= wptr[k] + AW'(push[k]);
                rptr[k] <= rptr[k] + AW'(pop[k]);
                cnt[k] <= cnt[k] + (AW+1)'(push[k]) - (AW+1)'(pop[k]);
                if (valid_i[k] && !ready_o[k])
                    overflow_o[k] <= 1'b1;
            end
            if (load) begin
                valid_o <= grant;
                data_o <= grant ? head : '0;
                chan_o <= grant ? gch : chan_o;
            end
            if (grant && mode)
                rr_ptr <= gch;
        end
    end
endmodule

// File: tb/tb_dec_out_arbiter.sv
// tb_dec_out_arbiter: directed self-checking bench for dec_out_arbiter (N_CH=4 and N_CH=3 instances).
module tb_dec_out_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [31:0] data_i;
    logic [3:0]  valid_i, ready_o, overflow_o;
    logic        mode, valid_o, ready_i;
    logic [1:0]  select, chan_o;
    logic [7:0]  data_o;
    logic [23:0] data_i3;
    logic [2:0]  valid_i3, ready_o3, overflow_o3;
    logic        mode3, valid_o3, ready_i3;
    logic [1:0]  select3, chan_o3;
    logic [7:0]  data_o3;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dec_out_arbiter #(.D_WIDTH(8), .N_CH(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .overflow_o(overflow_o), .mode(mode), .select(select), .data_o(data_o),
        .valid_o(valid_o), .chan_o(chan_o), .ready_i(ready_i));

    dec_out_arbiter #(.D_WIDTH(8), .N_CH(3), .FIFO_DEPTH(4)) dut3 (
        .clk(clk), .rst(rst), .data_i(data_i3), .valid_i(valid_i3), .ready_o(ready_o3),
        .overflow_o(overflow_o3), .mode(mode3), .select(select3), .data_o(data_o3),
        .valid_o(valid_o3), .chan_o(chan_o3), .ready_i(ready_i3));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_i = '0;
        valid_i3 = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_i = 4'hF;
        data_i = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (valid_o !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", valid_o); failures++; end
            checks++; if (data_o !== 8'h00) begin $display("FAIL reset_data got=%h exp=00", data_o); failures++; end
            checks++; if (ready_o !== 4'h0) begin $display("FAIL reset_ready got=%h exp=0", ready_o); failures++; end
            checks++; if (overflow_o !== 4'h0) begin $display("FAIL reset_overflow got=%h exp=0", overflow_o); failures++; end
        end
        rst = 1'b0;
        valid_i = '0;
        #1;
        checks++; if (ready_o !== 4'hF) begin $display("FAIL release_ready got=%h exp=F", ready_o); failures++; end
        checks++; if (ready_o3 !== 3'h7) begin $display("FAIL release_ready3 got=%h exp=7", ready_o3); failures++; end
    endtask

    task automatic test_fixed();
        do_reset();
        mode = 1'b0; select = 2'd2; ready_i = 1'b1;
        data_i = {8'h00, 8'hA5, 8'h00, 8'h55};
        valid_i = 4'b0101;
        step();
        valid_i = '0;
        checks++; if (valid_o !== 1'b0) begin $display("FAIL fixed_lat_early got=%b exp=0", valid_o); failures++; end
        step();
        checks++; if ({valid_o, chan_o, data_o} !== {1'b1, 2'd2, 8'hA5}) begin $display("FAIL fixed_out got=%b/%0d/%h exp=1/2/a5", valid_o, chan_o, data_o); failures++; end
        step();
        checks++; if ({valid_o, data_o} !== {1'b0, 8'h00}) begin $display("FAIL fixed_idle got=%b/%h exp=0/00", valid_o, data_o); failures++; end
        checks++; if (chan_o !== 2'd2) begin $display("FAIL fixed_chan_hold got=%0d exp=2", chan_o); failures++; end
        step();
        checks++; if (valid_o !== 1'b0) begin $display("FAIL fixed_ch0_buffered got=%b exp=0", valid_o); failures++; end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [5];
        logic [1:0] exp_c [5];
        exp_d = '{8'h10, 8'h20, 8'h30, 8'h11, 8'h00};
        exp_c = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd0};
        do_reset();
        mode = 1'b0; select = 2'd2; ready_i = 1'b1;
        data_i = {8'h30, 8'h00, 8'h20, 8'h10};
        valid_i = 4'b1011;
        step();
        data_i = {8'h00, 8'h00, 8'h00, 8'h11};
        valid_i = 4'b0001;
        step();
        checks++; if (valid_o !== 1'b0) begin $display("FAIL rr_preload_idle got=%b exp=0", valid_o); failures++; end
        valid_i = '0;
        mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (i < 4 && {valid_o, chan_o, data_o} !== {1'b1, exp_c[i], exp_d[i]}) begin
                $display("FAIL rr_seq%0d got=%b/%0d/%h exp=1/%0d/%h", i, valid_o, chan_o, data_o, exp_c[i], exp_d[i]); failures++;
            end
            if (i == 4 && {valid_o, data_o} !== {1'b0, 8'h00}) begin
                $display("FAIL rr_end got=%b/%h exp=0/00", valid_o, data_o); failures++;
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mode = 1'b0; select = 2'd0; ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_i = {16'h0, 8'hB0 + 8'(i), 8'h00};
            valid_i = 4'b0010;
            step();
            if (i == 2) begin
                checks++; if (ready_o[1] !== 1'b1) begin $display("FAIL bp_ready3 got=%b exp=1", ready_o[1]); failures++; end
            end
            if (i == 3) begin
                checks++; if (ready_o[1] !== 1'b0) begin $display("FAIL bp_full got=%b exp=0", ready_o[1]); failures++; end
                checks++; if (overflow_o !== 4'h0) begin $display("FAIL bp_no_ovf got=%h exp=0", overflow_o); failures++; end
            end
        end
        valid_i = '0;
        checks++; if (overflow_o !== 4'b0010) begin $display("FAIL bp_ovf got=%h exp=2", overflow_o); failures++; end
        select = 2'd1;
        step();
        checks++; if ({valid_o, data_o} !== {1'b1, 8'hB0}) begin $display("FAIL bp_first got=%b/%h exp=1/b0", valid_o, data_o); failures++; end
        checks++; if (ready_o[1] !== 1'b1) begin $display("FAIL bp_ready_rise got=%b exp=1", ready_o[1]); failures++; end
        step();
        checks++; if ({valid_o, data_o} !== {1'b1, 8'hB0}) begin $display("FAIL bp_hold got=%b/%h exp=1/b0", valid_o, data_o); failures++; end
        ready_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            checks++; if ({valid_o, chan_o, data_o} !== {1'b1, 2'd1, 8'hB0 + 8'(i)}) begin $display("FAIL bp_drain%0d got=%b/%0d/%h exp=1/1/%h", i, valid_o, chan_o, data_o, 8'hB0 + 8'(i)); failures++; end
        end
        step();
        checks++; if (valid_o !== 1'b0) begin $display("FAIL bp_empty got=%b exp=0", valid_o); failures++; end
        checks++; if (overflow_o !== 4'b0010) begin $display("FAIL bp_ovf_sticky got=%h exp=2", overflow_o); failures++; end
    endtask

    task automatic test_out_of_range();
        do_reset();
        mode3 = 1'b0; select3 = 2'd3; ready_i3 = 1'b1;
        data_i3 = {16'h0, 8'hC3};
        valid_i3 = 3'b001;
        step();
        valid_i3 = '0;
        step();
        step();
        checks++; if (valid_o3 !== 1'b0) begin $display("FAIL oor_no_grant got=%b exp=0", valid_o3); failures++; end
        select3 = 2'd0;
        step();
        checks++; if ({valid_o3, chan_o3, data_o3} !== {1'b1, 2'd0, 8'hC3}) begin $display("FAIL oor_sel0 got=%b/%0d/%h exp=1/0/c3", valid_o3, chan_o3, data_o3); failures++; end
    endtask

    task automatic test_mid_reset();
        do_reset();
        mode = 1'b1; ready_i = 1'b0;
        data_i = {8'h00, 8'h60, 8'h50, 8'h40};
        valid_i = 4'b0111;
        step();
        data_i = {8'h00, 8'h00, 8'h51, 8'h41};
        valid_i = 4'b0011;
        step();
        valid_i = '0;
        checks++; if ({valid_o, data_o} !== {1'b1, 8'h40}) begin $display("FAIL mid_pre got=%b/%h exp=1/40", valid_o, data_o); failures++; end
        rst = 1'b1;
        step();
        checks++; if ({valid_o, data_o, ready_o} !== {1'b0, 8'h00, 4'h0}) begin $display("FAIL mid_rst got=%b/%h/%h exp=0/00/0", valid_o, data_o, ready_o); failures++; end
        rst = 1'b0;
        ready_i = 1'b1;
        data_i = {8'h00, 8'h00, 8'h70, 8'h71};
        valid_i = 4'b0011;
        #1;
        checks++; if (ready_o !== 4'hF) begin $display("FAIL mid_ready got=%h exp=F", ready_o); failures++; end
        step();
        valid_i = '0;
        step();
        checks++; if ({valid_o, chan_o, data_o} !== {1'b1, 2'd0, 8'h71}) begin $display("FAIL mid_rr_ch0 got=%b/%0d/%h exp=1/0/71", valid_o, chan_o, data_o); failures++; end
        step();
        checks++; if ({valid_o, chan_o, data_o} !== {1'b1, 2'd1, 8'h70}) begin $display("FAIL mid_rr_ch1 got=%b/%0d/%h exp=1/1/70", valid_o, chan_o, data_o); failures++; end
        step();
        checks++; if (valid_o !== 1'b0) begin $display("FAIL mid_flushed got=%b exp=0", valid_o); failures++; end
    endtask

    initial begin
        rst = 1'b1;
        data_i = '0; valid_i = '0; mode = 1'b0; select = '0; ready_i = 1'b0;
        data_i3 = '0; valid_i3 = '0; mode3 = 1'b0; select3 = '0; ready_i3 = 1'b0;
        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_out_of_range();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
